// File: rtl/icache_pkg.sv
// Shared types and width helpers for the N-way instruction cache.
//   state_e : controller states
//   OKAY    : memory read response code for a clean beat
//   off_w / idx_w / tag_w : address field widths from the cache geometry
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESP,
    S_AR,
    S_FILL,
    S_FENCE
  } state_e;

  localparam logic [1:0] OKAY = 2'b00;

  function automatic int off_w(input int line_words, input int data_w);
    return $clog2(line_words * data_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets,
                               input int line_words, input int data_w);
    return addr_w - idx_w(sets) - off_w(line_words, data_w);
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Replacement way selection for one cache set at a time.
//   clk, rst  : clock, synchronous active-high reset (pointers return to 0)
//   valid_i   : valid bits of the addressed set
//   idx_i     : set index
//   advance_i : a miss is allocating in this set this cycle
//   victim_o  : lowest-index invalid way, else the set's round-robin pointer
// The pointer only moves when it was actually used to pick the victim.
module icache_victim_sel #(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int IDX_W = 6,
  parameter int WAY_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WAYS-1:0]  valid_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             advance_i,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] rr_q [SETS];
  logic             any_invalid;
  logic [WAY_W-1:0] free_way;

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    any_invalid = 1'b0;
    free_way    = '0;
    // Scan downwards so the lowest invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        any_invalid = 1'b1;
        free_way    = WAY_W'(w);
      end
    end
    victim_o = any_invalid ? free_way : rr_q[idx_i];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (advance_i && !any_invalid) begin
      rr_q[idx_i] <= (rr_q[idx_i] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_i] + 1'b1;
    end
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache.
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : fetch request (valid/ready/address)
//   rsp_*           : fetch response (valid/ready/data/bus error)
//   fence_i         : invalidate whole cache (pulse or level)
//   fence_done_o    : one-cycle pulse when invalidation is performed
//   mem_ar_*        : line burst request, len = LINE_WORDS-1
//   mem_r_*         : burst data beats with response code
// Hits answer one cycle after accept; misses refill a whole line then answer.
module icache_nway
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  input  logic              fence_i,
  output logic              fence_done_o,
  output logic              mem_ar_valid_o,
  input  logic              mem_ar_ready_i,
  output logic [ADDR_W-1:0] mem_ar_addr_o,
  output logic [7:0]        mem_ar_len_o,
  input  logic              mem_r_valid_i,
  output logic              mem_r_ready_o,
  input  logic [DATA_W-1:0] mem_r_data_i,
  input  logic [1:0]        mem_r_resp_i
);

  localparam int OFF_W  = off_w(LINE_WORDS, DATA_W);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS, DATA_W);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WORD_W = OFF_W - BYTE_W;
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  // Storage
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [DATA_W-1:0] data_q  [WAYS][SETS][LINE_WORDS];

  // Controller registers
  state_e            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;
  logic              fence_pend_q, fence_pend_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  // Request address fields; the byte-within-word bits play no part.
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic [IDX_W-1:0]  fill_idx;
  logic              unused_byte_bits;

  assign req_tag          = req_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx          = req_addr_i[OFF_W +: IDX_W];
  assign req_word         = req_addr_i[BYTE_W +: WORD_W];
  assign fill_idx         = line_q[IDX_W-1:0];
  assign unused_byte_bits = ^req_addr_i[BYTE_W-1:0];

  // Tag lookup across all ways of the requested set
  logic             hit;
  logic [WAY_W-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  logic             miss_alloc;
  logic [WAY_W-1:0] victim;

  icache_victim_sel #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_victim (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_q[req_idx]),
    .idx_i     (req_idx),
    .advance_i (miss_alloc),
    .victim_o  (victim)
  );

  logic fill_we, fill_validate, fence_clr;

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    word_d        = word_q;
    way_d         = way_q;
    beat_d        = beat_q;
    err_d         = err_q;
    fence_pend_d  = fence_pend_q;
    rsp_data_d    = rsp_data_q;
    miss_alloc    = 1'b0;
    fill_we       = 1'b0;
    fill_validate = 1'b0;
    fence_clr     = 1'b0;

    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    fence_done_o   = 1'b0;
    mem_ar_valid_o = 1'b0;
    mem_ar_addr_o  = '0;
    mem_r_ready_o  = 1'b0;

    // A fence arriving mid-transaction is remembered and run at the next IDLE.
    // One seen during FENCE is already satisfied by that cycle's clear.
    if (fence_i && (state_q != S_IDLE) && (state_q != S_FENCE)) fence_pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        // fence_i gates ready combinationally so a fence never races a request.
        req_ready_o = !rst && !fence_i && !fence_pend_q;
        if (fence_i || fence_pend_q) begin
          state_d = S_FENCE;
        end else if (req_valid_i) begin
          line_d = req_addr_i[ADDR_W-1:OFF_W];
          word_d = req_word;
          if (hit) begin
            rsp_data_d = data_q[hit_way][req_idx][req_word];
            state_d    = S_RESP;
          end else begin
            way_d      = victim;
            beat_d     = '0;
            miss_alloc = 1'b1;
            state_d    = S_AR;
          end
        end
      end
      S_FENCE: begin
        fence_clr    = 1'b1;
        fence_done_o = 1'b1;
        fence_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      S_AR: begin
        mem_ar_valid_o = 1'b1;
        mem_ar_addr_o  = {line_q, {OFF_W{1'b0}}};
        if (mem_ar_ready_i) state_d = S_FILL;
      end
      S_FILL: begin
        mem_r_ready_o = 1'b1;
        if (mem_r_valid_i) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (mem_r_resp_i != OKAY) err_d = 1'b1;
          if (beat_q == word_q) rsp_data_d = mem_r_data_i;
          if (beat_q == LAST_BEAT) begin
            // err_d already folds in this beat's response.
            fill_validate = !err_d;
            state_d       = S_RESP;
          end
        end
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = err_q;
  assign mem_ar_len_o = 8'(LINE_WORDS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      word_q       <= '0;
      way_q        <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      fence_pend_q <= 1'b0;
      rsp_data_q   <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      word_q       <= word_d;
      way_q        <= way_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      fence_pend_q <= fence_pend_d;
      rsp_data_q   <= rsp_data_d;
      if (fence_clr) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (miss_alloc) begin
        valid_q[req_idx][victim] <= 1'b0;
      end else if (fill_validate) begin
        valid_q[fill_idx][way_q] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays are deliberately left out of reset; the valid
  // bits alone decide whether their contents are ever used.
  always_ff @(posedge clk) begin
    if (miss_alloc) tag_q[victim][req_idx] <= req_tag;
    if (fill_we) data_q[way_q][fill_idx][beat_q] <= mem_r_data_i;
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway with default geometry (16-byte lines,
// IDX = addr[9:4], word select = addr[3]). A small memory model supplies
// line data; expected responses are queued when a fetch is issued and
// compared when the cache responds.
module tb_icache_nway;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_data;
  logic        fence_in, fence_done;
  logic        mem_ar_valid, mem_ar_ready;
  logic [31:0] mem_ar_addr;
  logic [7:0]  mem_ar_len;
  logic        mem_r_valid, mem_r_ready;
  logic [63:0] mem_r_data;
  logic [1:0]  mem_r_resp;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  icache_nway dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_data_o     (rsp_data),
    .rsp_err_o      (rsp_err),
    .fence_i        (fence_in),
    .fence_done_o   (fence_done),
    .mem_ar_valid_o (mem_ar_valid),
    .mem_ar_ready_i (mem_ar_ready),
    .mem_ar_addr_o  (mem_ar_addr),
    .mem_ar_len_o   (mem_ar_len),
    .mem_r_valid_i  (mem_r_valid),
    .mem_r_ready_o  (mem_r_ready),
    .mem_r_data_i   (mem_r_data),
    .mem_r_resp_i   (mem_r_resp)
  );

  // Memory contents: the first test line holds 0x11/0x22, others a tagged pattern.
  function automatic logic [63:0] mem_word(input logic [31:0] line, input int beat);
    if (line == 32'h8000_0000) return (beat == 0) ? 64'h11 : 64'h22;
    return {line, 16'hC0DE, 8'h00, 8'(beat)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue one fetch from a negedge; returns at the negedge after the response
  // handshake. Misses get the AR held off one cycle, then two beats.
  task automatic fetch(input string tag, input logic [31:0] addr, input bit exp_hit,
                       input bit err_beat1, input int stall, input bit fence_in_fill);
    logic [31:0] line;
    rsp_t        r;
    int          n;
    line = {addr[31:4], 4'h0};
    r.data = mem_word(line, int'(addr[3]));
    r.err  = !exp_hit && err_beat1;
    exp_q.push_back(r);

    req_addr  = addr;
    req_valid = 1'b1;
    n = 0;
    #1;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "/accept"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "/ar_t1"}, mem_ar_valid, !exp_hit);
    check({tag, "/rsp_t1"}, rsp_valid, exp_hit);

    if (!exp_hit) begin
      check({tag, "/ar_addr"}, mem_ar_addr, line);
      check({tag, "/ar_len"}, mem_ar_len, 8'd1);
      @(negedge clk);
      check({tag, "/ar_hold"}, mem_ar_valid, 1);
      check({tag, "/r_ready_pre"}, mem_r_ready, 0);
      mem_ar_ready = 1'b1;
      @(negedge clk);
      mem_ar_ready = 1'b0;
      check({tag, "/r_ready"}, mem_r_ready, 1);
      for (int b = 0; b < 2; b++) begin
        mem_r_valid = 1'b1;
        mem_r_data  = mem_word(line, b);
        mem_r_resp  = (b == 1 && err_beat1) ? 2'b10 : OKAY;
        fence_in    = fence_in_fill && (b == 0);
        @(negedge clk);
      end
      mem_r_valid = 1'b0;
      mem_r_resp  = OKAY;
      fence_in    = 1'b0;
      check({tag, "/rsp_after_fill"}, rsp_valid, 1);
    end

    repeat (stall) begin
      check({tag, "/stall_valid"}, rsp_valid, 1);
      check({tag, "/stall_data"}, rsp_data, r.data);
      check({tag, "/stall_req_ready"}, req_ready, 0);
      @(negedge clk);
    end

    check({tag, "/sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      check({tag, "/rsp_valid"}, rsp_valid, 1);
      check({tag, "/rsp_data"}, rsp_data, r.data);
      check({tag, "/rsp_err"}, rsp_err, r.err);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "/rsp_drop"}, rsp_valid, 0);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_addr     = '0;
    rsp_ready    = 1'b0;
    fence_in     = 1'b0;
    mem_ar_ready = 1'b0;
    mem_r_valid  = 1'b0;
    mem_r_data   = '0;
    mem_r_resp   = OKAY;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst/req_ready", req_ready, 0);
    check("rst/rsp_valid", rsp_valid, 0);
    check("rst/rsp_data", rsp_data, 0);
    check("rst/rsp_err", rsp_err, 0);
    check("rst/ar_valid", mem_ar_valid, 0);
    check("rst/ar_addr", mem_ar_addr, 0);
    check("rst/r_ready", mem_r_ready, 0);
    check("rst/fence_done", fence_done, 0);
    rst = 1'b0;
    #1;
    check("idle/req_ready", req_ready, 1);
    @(negedge clk);

    // Cold miss then hit on the same line
    fetch("cold_miss", 32'h8000_0008, 1'b0, 1'b0, 0, 1'b0);
    fetch("hit_w0", 32'h8000_0000, 1'b1, 1'b0, 0, 1'b0);

    // Hit with the consumer stalling five cycles
    fetch("hit_stall", 32'h8000_0008, 1'b1, 1'b0, 5, 1'b0);

    // Fence during a fill: fill completes, then FENCE, then everything misses
    fetch("fence_fill", 32'h8000_1010, 1'b0, 1'b0, 0, 1'b1);
    #1;
    check("fence/pend_blocks_req", req_ready, 0);
    check("fence/no_early_done", fence_done, 0);
    @(negedge clk);
    check("fence/done_pulse", fence_done, 1);
    @(negedge clk);
    check("fence/done_low", fence_done, 0);
    check("fence/req_ready_back", req_ready, 1);
    fetch("post_fence_a", 32'h8000_0000, 1'b0, 1'b0, 0, 1'b0);
    fetch("post_fence_b", 32'h8000_1010, 1'b0, 1'b0, 0, 1'b0);

    // Set-0 replacement: k=0 already in way 0, k=1..3 fill ways 1..3,
    // k=4 evicts way 0 via the round-robin pointer.
    for (int k = 1; k <= 4; k++)
      fetch($sformatf("set0_fill%0d", k), 32'h8000_0000 + 32'(k) * 32'h400, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 1; k <= 4; k++)
      fetch($sformatf("set0_hit%0d", k), 32'h8000_0000 + 32'(k) * 32'h400, 1'b1, 1'b0, 0, 1'b0);
    fetch("set0_evicted", 32'h8000_0000, 1'b0, 1'b0, 0, 1'b0);

    // Bus error on the last beat: error reported, line stays invalid
    fetch("err_fill", 32'h9000_0028, 1'b0, 1'b1, 0, 1'b0);
    fetch("err_refetch", 32'h9000_0028, 1'b0, 1'b0, 0, 1'b0);
    fetch("err_then_hit", 32'h9000_0028, 1'b1, 1'b0, 0, 1'b0);

    // Reset in the middle of a fill
    req_addr  = 32'hA000_0030;
    req_valid = 1'b1;
    #1;
    check("rstfill/accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstfill/ar", mem_ar_valid, 1);
    mem_ar_ready = 1'b1;
    @(negedge clk);
    mem_ar_ready = 1'b0;
    mem_r_valid  = 1'b1;
    mem_r_data   = mem_word(32'hA000_0030, 0);
    @(negedge clk);
    mem_r_valid = 1'b0;
    check("rstfill/still_fill", mem_r_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstfill/req_ready", req_ready, 0);
    check("rstfill/rsp_valid", rsp_valid, 0);
    check("rstfill/rsp_data", rsp_data, 0);
    check("rstfill/rsp_err", rsp_err, 0);
    check("rstfill/ar_valid", mem_ar_valid, 0);
    check("rstfill/ar_addr", mem_ar_addr, 0);
    check("rstfill/r_ready", mem_r_ready, 0);
    check("rstfill/fence_done", fence_done, 0);
    rst = 1'b0;
    @(negedge clk);
    fetch("rstfill_miss", 32'hA000_0030, 1'b0, 1'b0, 0, 1'b0);
    fetch("rst_empty", 32'h8000_0800, 1'b0, 1'b0, 0, 1'b0);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised N-way set-associative, read-only instruction cache between the IFU fetch port and the AXI-style memory read channel. It generalises the current 2-way icache in ways, sets, line length and data width. It adds round-robin replacement that fills invalid ways first, `fence.i` whole-cache invalidation, and propagation of bus error responses. Hits return one cycle after acceptance; misses fetch a full line in one burst.

## Interface
- `ADDR_W`, 32: physical address width.
- `DATA_W`, 64: fetch word and bus beat width.
- `WAYS`, 4: associativity, power of 2, ≥1.
- `SETS`, 64: sets, power of 2.
- `LINE_WORDS`, 2: words per line and beats per fill, power of 2, ≥2.

Derived widths:
- OFF_W = log2(LINE_WORDS·DATA_W/8).
- IDX_W = log2(SETS).
- TAG_W = ADDR_W−IDX_W−OFF_W.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1, `req_ready` out 1, `req_addr` in ADDR_W: fetch request.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out DATA_W, `rsp_err` out 1: fetch response.
- `fence_i` in 1: invalidate request, pulse or level.
- `fence_done` out 1: one-cycle pulse when invalidation has been performed.
- `mem_ar_valid` out 1, `mem_ar_ready` in 1, `mem_ar_addr` out ADDR_W, `mem_ar_len` out 8: burst request; `mem_ar_len` = LINE_WORDS−1.
- `mem_r_valid` in 1, `mem_r_ready` out 1, `mem_r_data` in DATA_W, `mem_r_resp` in 2: burst data.

## Operation
- States:
  - IDLE: `req_ready`=1 unless a fence is pending.
  - RESP.
  - AR.
  - FILL.
  - FENCE.
- IDLE with `fence_i` or the pending-fence flag set goes to FENCE. A fence takes priority over `req_valid`.
- FENCE clears every valid bit in one cycle, pulses `fence_done`, and returns to IDLE.
- A `fence_i` seen outside IDLE sets the pending flag. The fence is executed on the next IDLE.
- Accept condition: `req_valid`&&`req_ready`. On accept:
  - Latch the address.
  - Compare the tag against all ways of `req_addr[IDX]`. Hit means tag equal and valid bit set.
  - Hit: register the data word selected by the offset's word bits, then go to RESP.
  - Miss: select a victim, clear its valid bit, write its tag, then go to AR.
- Victim selection: the lowest-index invalid way if one exists. Otherwise the per-set round-robin pointer, which then advances by 1 mod WAYS.
- AR drives `mem_ar_valid`=1 and `mem_ar_addr`={tag,index,OFF_W'0}. The state holds until `mem_ar_ready`, then goes to FILL.
- FILL:
  - `mem_r_ready`=1.
  - Each beat writes the word at the beat counter position, counting from 0.
  - The requested word is captured when the counter equals the requested word index.
  - Any `mem_r_resp`≠0 sets a sticky error flag.
  - At beat LINE_WORDS−1 the valid bit is set only if the error flag is clear. The state then goes to RESP.
- RESP drives `rsp_valid`=1 with `rsp_data` and `rsp_err` stable. The state holds until `rsp_ready`, then goes to IDLE. The error flag clears on exit.
- A hit never sets `rsp_err`.

## Timing
- Reset values:
  - `req_ready`=0 in the reset cycle, 1 from the first IDLE cycle.
  - `rsp_valid`, `rsp_data`, `rsp_err`, `mem_ar_valid`, `mem_ar_addr`, `mem_r_ready` and `fence_done` are all 0.
  - All valid bits and round-robin pointers are 0. The data array is not reset.
- Hit latency: accept at T gives `rsp_valid` at T+1. Best-case throughput is one fetch per 2 cycles.
- Miss: `mem_ar_valid` asserts at T+1. Let A be the cycle `mem_ar_ready` is seen and L the cycle of the last beat. `mem_r_ready` is asserted from A+1; `rsp_valid` asserts at L+1.
- `mem_r_valid` is ignored outside FILL. Beats beyond LINE_WORDS are not expected.
- `rst` mid-burst abandons the transaction, with the interconnect reset alongside. The cache is empty afterwards.
- A fence pulse arriving in the same cycle as a RESP handshake executes in the following IDLE cycle, before any new request.

## Structure
- Package `icache_pkg`:
  - state enum.
  - `clog2`-based width functions for OFF_W, IDX_W and TAG_W.
  - `OKAY` resp constant.
- Sub-module `icache_victim_sel`: per-set round-robin pointers plus the invalid-first priority encoder. Inputs are the set's valid vector, the index, and an advance strobe; output is the victim way.
- Tag and valid storage is in flops; data storage is a `WAYS`×`SETS`×`LINE_WORDS` register array.

## Test plan
All scenarios use default parameters: 16-byte line, IDX=[9:4], TAG=[31:10].
- Cold miss to 0x8000_0008:
  - Response: `mem_ar_addr`=0x8000_0000, `mem_ar_len`=1.
  - Beats 0x11, 0x22: `rsp_data`=0x22, `rsp_err`=0.
  - Repeat fetch of 0x8000_0000: hit with `rsp_valid` at T+1, data 0x11, no AR.
- Five line addresses mapping to set 0 (0x8000_0000 + k·0x400, k=0..4):
  - Fills go to ways 0-3, then the fifth evicts way 0.
  - Refetching k=0 misses; k=1 still hits.
- Miss with beat 1 `mem_r_resp`=2'b10:
  - Response: `rsp_err`=1.
  - The refetch misses again, because the line was not validated.
- `fence_i` asserted during FILL:
  - The fill completes and the response is delivered.
  - FENCE follows with a `fence_done` pulse.
  - All previously cached addresses then miss.
- `rsp_ready` held low for 5 cycles on a hit: `rsp_valid` and `rsp_data` stay stable, and `req_ready`=0 throughout.
- `rst` asserted in FILL after beat 0: the next cycle shows all outputs at their reset values, and a later fetch of the same address misses.
